// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C EEPROM slave byte sequencer.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN uses the maj3() helper below.
package i2c_slave_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEVADDR,
        S_DEVACK,
        S_WADDR,
        S_WADDRACK,
        S_WRDATA,
        S_WRACK,
        S_RDLOAD,
        S_RDDATA,
        S_RDACK,
        S_WAITSTOP
    } state_e;

    localparam logic        ACK_BIT          = 1'b0;
    localparam logic        NACK_BIT         = 1'b1;
    localparam int unsigned RW_BIT           = 0;
    localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h50;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// SCL/SDA synchronizers and registered START/STOP/edge pulse generation.
// I2C_SLAVE_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronizers.
module i2c_bus_monitor
    import i2c_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_c;
    logic                   sda_c;
    logic                   scl_d;
    logic                   sda_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;
    logic       scl_f;
    logic       sda_f;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
            scl_f    <= maj3(scl_hist);
            sda_f    <= maj3(sda_hist);
        end
    end

    assign scl_c = scl_f;
    assign sda_c = sda_f;
`else
    assign scl_c = scl_sync[SYNC_STAGES-1];
    assign sda_c = sda_sync[SYNC_STAGES-1];
`endif

    // Pulses are registered so they line up with the delayed levels on scl/sda.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_d    <= scl_c;
            sda_d    <= sda_c;
            scl_rise <= scl_c & ~scl_d;
            scl_fall <= ~scl_c & scl_d;
            start    <= scl_c & scl_d & sda_d & ~sda_c;
            stop     <= scl_c & scl_d & ~sda_d & sda_c;
        end
    end

    assign scl = scl_d;
    assign sda = sda_d;

endmodule

// File: rtl/i2c_eeprom_slave_ctrl.sv
// I2C EEPROM slave byte sequencer: address decode, ACK/read-data drive, memory port.
// Build option I2C_SLAVE_GLITCH_FILTER_EN enables majority filtering in i2c_bus_monitor.
module i2c_eeprom_slave_ctrl
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic bus_scl, bus_sda, scl_rise, scl_fall, start, stop;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl      (bus_scl),
        .sda      (bus_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [7:0]        shreg, shreg_n;
    logic              rw, rw_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic              sda_oe_n, busy_n, we_n, re_n;
    logic              byte_done, byte_done_n;
    logic [1:0]        rd_ph, rd_ph_n;
    logic              lead, lead_n;

    logic       rx_state, rx_bit, rx_last;
    logic [7:0] byte_in;

    assign rx_state = (state == S_DEVADDR) || (state == S_WADDR) || (state == S_WRDATA);
    assign rx_bit   = rx_state && scl_rise && !byte_done;
    assign rx_last  = rx_bit && (cnt == 3'd7);
    assign byte_in  = {shreg[6:0], bus_sda};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            byte_done <= 1'b0;
            rd_ph     <= '0;
            lead      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            rw        <= rw_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
            byte_done <= byte_done_n;
            rd_ph     <= rd_ph_n;
            lead      <= lead_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        rw_n        = rw;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        we_n        = 1'b0;
        re_n        = 1'b0;
        byte_done_n = byte_done;
        rd_ph_n     = rd_ph;
        lead_n      = lead;

        // The data write is decided independently of START/STOP in the same cycle.
        if (rx_last && state == S_WRDATA) begin
            we_n    = 1'b1;
            wdata_n = byte_in;
        end

        if (start) begin
            state_n     = S_DEVADDR;
            cnt_n       = '0;
            sda_oe_n    = 1'b0;
            byte_done_n = 1'b0;
            rd_ph_n     = '0;
            lead_n      = 1'b0;
        end else if (stop) begin
            state_n     = S_IDLE;
            cnt_n       = '0;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            byte_done_n = 1'b0;
        end else begin
            case (state)
                S_DEVADDR, S_WADDR, S_WRDATA: begin
                    if (byte_done && scl_fall) begin
                        byte_done_n = 1'b0;
                        sda_oe_n    = 1'b1;
                        state_n     = (state == S_DEVADDR) ? S_DEVACK :
                                      (state == S_WADDR)   ? S_WADDRACK : S_WRACK;
                    end else if (rx_bit) begin
                        shreg_n     = byte_in;
                        cnt_n       = cnt + 3'd1;
                        byte_done_n = rx_last;
                    end
                    if (rx_last && state == S_DEVADDR) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                            busy_n = 1'b1;
                            rw_n   = byte_in[RW_BIT];
                        end else begin
                            busy_n      = 1'b0;
                            byte_done_n = 1'b0;
                            state_n     = S_WAITSTOP;
                        end
                    end
                    if (rx_last && state == S_WADDR)
                        addr_n = ADDR_W'(byte_in);
                end
                S_DEVACK: if (scl_fall) begin
                    sda_oe_n = 1'b0;
                    cnt_n    = '0;
                    rd_ph_n  = '0;
                    state_n  = rw ? S_RDLOAD : S_WADDR;
                end
                S_WADDRACK: if (scl_fall) begin
                    sda_oe_n = 1'b0;
                    cnt_n    = '0;
                    state_n  = S_WRDATA;
                end
                S_WRACK: if (scl_fall) begin
                    sda_oe_n = 1'b0;
                    cnt_n    = '0;
                    addr_n   = mem_addr + 1'b1;
                    state_n  = S_WRDATA;
                end
                S_RDLOAD: begin
                    case (rd_ph)
                        2'd0: begin
                            re_n    = 1'b1;
                            rd_ph_n = 2'd1;
                        end
                        2'd1: rd_ph_n = 2'd2;
                        default: begin
                            // After a master ACK SCL is still high; hold the MSB until the fall.
                            shreg_n  = mem_rdata;
                            cnt_n    = '0;
                            rd_ph_n  = '0;
                            state_n  = S_RDDATA;
                            lead_n   = bus_scl;
                            sda_oe_n = bus_scl ? 1'b0 : ~mem_rdata[7];
                        end
                    endcase
                end
                S_RDDATA: if (scl_fall) begin
                    if (lead) begin
                        lead_n   = 1'b0;
                        sda_oe_n = ~shreg[7];
                    end else if (cnt == 3'd7) begin
                        sda_oe_n = 1'b0;
                        state_n  = S_RDACK;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                        cnt_n    = cnt + 3'd1;
                    end
                end
                S_RDACK: if (scl_rise) begin
                    if (bus_sda == ACK_BIT) begin
                        addr_n  = mem_addr + 1'b1;
                        rd_ph_n = '0;
                        state_n = S_RDLOAD;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = S_WAITSTOP;
                    end
                end
                S_IDLE, S_WAITSTOP: sda_oe_n = 1'b0;
                default: begin
                    state_n  = S_IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave_ctrl.sv
// Self-checking bench: bit-banged I2C master, memory model and write/read scoreboards.
// Glitch test runs only when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module tb_i2c_eeprom_slave_ctrl;
    import i2c_slave_pkg::*;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy;

    logic [7:0]  mem [256];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic        exp_ack_q [$];

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    logic oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_eeprom_slave_ctrl #(.DEV_ADDR(7'h50), .ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    // Write scoreboard: every mem_we pulse must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (mem_re) re_cnt++;
        if (mem_we) begin
            logic [15:0] e;
            we_cnt++;
            n_vec++;
            if (exp_wr_q.size() == 0) begin
                n_err++;
                $display("FAIL mem_write: got addr=%02h data=%02h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL mem_write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                             mem_addr, mem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    task automatic hclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        hclk(T/2); sda_m = 1'b1;
        hclk(T/2); scl_m = 1'b1;
        hclk(T);   sda_m = 1'b0;
        hclk(T);   scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        hclk(T/2); sda_m = 1'b0;
        hclk(T/2); scl_m = 1'b1;
        hclk(T);   sda_m = 1'b1;
        hclk(T);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input int glitch_bit);
        logic ack, e;
        exp_ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) begin
            hclk(T/2); sda_m = b[i];
            hclk(T/2); scl_m = 1'b1;
            if (glitch_bit == i) begin
                hclk(T/2); scl_m = 1'b0;
                hclk(1);   scl_m = 1'b1;
                hclk(T/2 - 1);
            end else begin
                hclk(T);
            end
            scl_m = 1'b0;
        end
        hclk(T/2); sda_m = 1'b1;
        hclk(T/2); scl_m = 1'b1;
        hclk(T/2); ack = sda_line;
        hclk(T/2); scl_m = 1'b0;
        e = exp_ack_q.pop_front();
        n_vec++;
        if (ack !== e) begin
            n_err++;
            $display("FAIL ack_byte_%02h: got %b, required %b", b, ack, e);
        end
    endtask

    task automatic read_byte(input logic [7:0] exp_data, input logic ack_bit);
        logic [7:0] d, e;
        exp_rd_q.push_back(exp_data);
        for (int i = 7; i >= 0; i--) begin
            hclk(T/2); sda_m = 1'b1;
            hclk(T/2); scl_m = 1'b1;
            hclk(T/2); d[i] = sda_line;
            hclk(T/2); scl_m = 1'b0;
        end
        hclk(T/2); sda_m = ack_bit;
        hclk(T/2); scl_m = 1'b1;
        hclk(T);   scl_m = 1'b0;
        e = exp_rd_q.pop_front();
        n_vec++;
        if (d !== e) begin
            n_err++;
            $display("FAIL read_data: got %08b, required %08b", d, e);
        end
    endtask

    task automatic check_idle_bus(input string name);
        n_vec++;
        if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got busy=%b sda_oe=%b, required busy=0 sda_oe=0", name, busy, sda_oe);
        end
    endtask

    task automatic check_writes_drained(input string name);
        n_vec++;
        if (exp_wr_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_wr_q.size());
            exp_wr_q.delete();
        end
    endtask

    task automatic test_reset();
        hclk(5);
        n_vec++;
        if ({sda_oe, mem_we, mem_re, busy} !== 4'b0000 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_values: got oe=%b we=%b re=%b busy=%b addr=%02h wdata=%02h, required all 0",
                     sda_oe, mem_we, mem_re, busy, mem_addr, mem_wdata);
        end
        reset_n = 1'b1;
        hclk(T);
    endtask

    task automatic test_write();
        exp_wr_q.push_back({8'h10, 8'hA5});
        exp_wr_q.push_back({8'h11, 8'h3C});
        i2c_start();
        write_byte(8'hA0, ACK_BIT, -1);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL write_busy: got %b, required 1", busy);
        end
        write_byte(8'h10, ACK_BIT, -1);
        write_byte(8'hA5, ACK_BIT, -1);
        write_byte(8'h3C, ACK_BIT, -1);
        i2c_stop();
        check_idle_bus("write_after_stop");
        check_writes_drained("write_drain");
    endtask

    task automatic test_random_read();
        mem[8'h20] = 8'h81;
        mem[8'h21] = 8'h7E;
        i2c_start();
        write_byte(8'hA0, ACK_BIT, -1);
        write_byte(8'h20, ACK_BIT, -1);
        i2c_start();
        write_byte(8'hA1, ACK_BIT, -1);
        read_byte(8'h81, ACK_BIT);
        read_byte(8'h7E, NACK_BIT);
        hclk(2);
        n_vec++;
        if (dut.state !== S_WAITSTOP || busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_nack_abort: got state=%0d busy=%b, required state=%0d busy=0",
                     dut.state, busy, S_WAITSTOP);
        end
        i2c_stop();
        check_idle_bus("read_after_stop");
    endtask

    task automatic test_no_match();
        oe_seen = 1'b0;
        we_cnt  = 0;
        re_cnt  = 0;
        i2c_start();
        write_byte(8'hA4, NACK_BIT, -1);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL nomatch_busy: got %b, required 0", busy);
        end
        write_byte(8'h00, NACK_BIT, -1);
        i2c_stop();
        n_vec++;
        if (oe_seen !== 1'b0 || we_cnt != 0 || re_cnt != 0) begin
            n_err++;
            $display("FAIL nomatch_quiet: got oe_seen=%b we=%0d re=%0d, required 0 0 0", oe_seen, we_cnt, re_cnt);
        end
    endtask

    task automatic test_wrap();
        exp_wr_q.push_back({8'hFF, 8'h11});
        exp_wr_q.push_back({8'h00, 8'h22});
        i2c_start();
        write_byte(8'hA0, ACK_BIT, -1);
        write_byte(8'hFF, ACK_BIT, -1);
        write_byte(8'h11, ACK_BIT, -1);
        write_byte(8'h22, ACK_BIT, -1);
        i2c_stop();
        check_writes_drained("wrap_drain");
    endtask

    task automatic test_reset_mid_read();
        int budget;
        mem[8'h30] = 8'h00;
        i2c_start();
        write_byte(8'hA0, ACK_BIT, -1);
        write_byte(8'h30, ACK_BIT, -1);
        i2c_start();
        write_byte(8'hA1, ACK_BIT, -1);
        sda_m  = 1'b1;
        budget = 60;
        while (!(dut.state == S_RDDATA && sda_oe === 1'b1) && budget > 0) begin
            hclk(1);
            budget--;
        end
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL rst_mid_read_drive: got sda_oe=%b, required 1 in RDDATA within 60 clk", sda_oe);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_read_release: got sda_oe=%b busy=%b, required 0 0", sda_oe, busy);
        end
        hclk(4);
        scl_m = 1'b1;
        hclk(T);
        reset_n = 1'b1;
        hclk(T);
        exp_wr_q.push_back({8'h40, 8'h5A});
        i2c_start();
        write_byte(8'hA0, ACK_BIT, -1);
        write_byte(8'h40, ACK_BIT, -1);
        write_byte(8'h5A, ACK_BIT, -1);
        i2c_stop();
        check_writes_drained("rst_fresh_write");
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch();
        exp_wr_q.push_back({8'h50, 8'hC3});
        i2c_start();
        write_byte(8'hA0, ACK_BIT, -1);
        write_byte(8'h50, ACK_BIT, -1);
        write_byte(8'hC3, ACK_BIT, 4);
        i2c_stop();
        check_writes_drained("glitch_drain");
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_random_read();
        test_no_match();
        test_wrap();
        test_reset_mid_read();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch();
`endif
        hclk(T);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
